// File: rtl/user_obi_sram_responder.sv
// OBI subordinate word memory for the user domain.
// Accepts one request per cycle, performs the byte-enabled write or the word
// read at the accept edge, and returns in-order responses after a fixed
// latency through a response FIFO that honours rready_i.
module user_obi_sram_responder #(
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          IdWidth     = 1,
    parameter int unsigned          NumWords    = 256,
    parameter logic [AddrWidth-1:0] BaseAddr    = '0,
    parameter int unsigned          ReadLatency = 1,
    parameter int unsigned          FifoDepth   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [IdWidth-1:0]   aid_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic [IdWidth-1:0]   rid_o,
    output logic                 err_o
);

    localparam int unsigned WordW = $clog2(NumWords);
    localparam int unsigned CntW  = $clog2(FifoDepth + ReadLatency) + 1;
    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [AddrWidth-1:0] SpanBytes = AddrWidth'(NumWords * 4);

    typedef struct packed {
        logic [IdWidth-1:0]   rid;
        logic                 err;
        logic [DataWidth-1:0] rdata;
    } resp_t;

    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 belowBase;
    logic [AddrWidth-1:0] offset;
    logic                 addrErr;
    logic [WordW-1:0]     wordIdx;
    logic                 accept;
    resp_t                acceptEntry;

    logic                 push;
    resp_t                pushEntry;
    logic                 pop;
    logic [CntW-1:0]      inflight;

    resp_t                fifoMem_q [FifoDepth];
    logic [PtrW-1:0]      wrPtr_q;
    logic [PtrW-1:0]      rdPtr_q;
    logic [CntW-1:0]      fifoCount_q;
    logic [CntW-1:0]      fifoCount_d;
    resp_t                head;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Address decode; the borrow of the widened subtraction flags addresses below the window
    always_comb begin
        {belowBase, offset} = {1'b0, addr_i} - {1'b0, BaseAddr};
        addrErr = belowBase || (offset >= SpanBytes) || (addr_i[1:0] != 2'b00);
        wordIdx = offset[WordW+1:2];
    end

    // Grant only while a response slot is still free across pipeline and FIFO
    always_comb begin
        gnt_o  = req_i && !rst_i && ((inflight + fifoCount_q) < CntW'(FifoDepth));
        accept = req_i && gnt_o;
        acceptEntry.rid   = aid_i;
        acceptEntry.err   = addrErr;
        acceptEntry.rdata = (!we_i && !addrErr) ? mem_q[wordIdx] : '0;
    end

    // Byte-enabled write committed at the accept edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !addrErr) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[wordIdx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    if (ReadLatency == 1) begin : g_direct
        assign push      = accept;
        assign pushEntry = acceptEntry;
        assign inflight  = '0;
    end else begin : g_pipe
        localparam int unsigned Stages = ReadLatency - 1;

        logic [Stages-1:0] pipeValid_q;
        resp_t             pipeEntry_q [Stages];
        logic [CntW-1:0]   inflight_q;
        logic [CntW-1:0]   inflight_d;

        // Track how many accepted responses are still travelling down the pipeline
        always_comb begin
            inflight_d = inflight_q;
            if (accept && !push) begin
                inflight_d = inflight_q + CntW'(1);
            end else if (!accept && push) begin
                inflight_d = inflight_q - CntW'(1);
            end
        end

        // Fixed-latency shift pipeline; it never stalls because slots were reserved at grant
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipeValid_q <= '0;
                inflight_q  <= '0;
                for (int s = 0; s < Stages; s++) begin
                    pipeEntry_q[s] <= '0;
                end
            end else begin
                pipeValid_q[0] <= accept;
                pipeEntry_q[0] <= acceptEntry;
                for (int s = 1; s < Stages; s++) begin
                    pipeValid_q[s] <= pipeValid_q[s-1];
                    pipeEntry_q[s] <= pipeEntry_q[s-1];
                end
                inflight_q <= inflight_d;
            end
        end

        assign push      = pipeValid_q[Stages-1];
        assign pushEntry = pipeEntry_q[Stages-1];
        assign inflight  = inflight_q;
    end

    // FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        fifoCount_d = fifoCount_q;
        case ({push, pop})
            2'b10:   fifoCount_d = fifoCount_q + CntW'(1);
            2'b01:   fifoCount_d = fifoCount_q - CntW'(1);
            default: fifoCount_d = fifoCount_q;
        endcase
    end

    // Response storage; stale entries are harmless because outputs are gated by rvalid
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= pushEntry;
        end
    end

    // FIFO pointers and count; reset drops every queued response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= nextPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            fifoCount_q <= fifoCount_d;
        end
    end

    // FIFO head drives the R channel, with the payload forced to zero when idle
    always_comb begin
        head     = fifoMem_q[rdPtr_q];
        rvalid_o = (fifoCount_q != '0);
        pop      = rvalid_o && rready_i;
        rdata_o  = rvalid_o ? head.rdata : '0;
        rid_o    = rvalid_o ? head.rid   : '0;
        err_o    = rvalid_o ? head.err   : 1'b0;
    end

endmodule

// File: tb/tb_user_obi_sram_responder.sv
// Directed testbench for user_obi_sram_responder with default parameters.
// A table of per-cycle vectors covers writes, reads, byte enables and address
// errors; hand-written sequences cover backpressure and mid-transfer reset.
module tb_user_obi_sram_responder;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [0:0]  aid_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic [0:0]  rid_o;
    logic        err_o;

    typedef struct {
        logic        rst;
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aid;
        logic        rready;
        logic        eGnt;
        logic        eValid;
        logic [31:0] eData;
        logic        eRid;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];
    int   vectorsApplied = 0;
    int   miscompares    = 0;

    user_obi_sram_responder dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .aid_i    (aid_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rready_i (rready_i),
        .rdata_o  (rdata_o),
        .rid_o    (rid_o),
        .err_o    (err_o)
    );

    // Free-running 10 ns clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic vec_t mk(input int rst, input int req, input int we, input int be,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int aid, input int rready,
                                input int eGnt, input int eValid, input logic [31:0] eData,
                                input int eRid, input int eErr);
        vec_t v;
        v.rst    = (rst != 0);
        v.req    = (req != 0);
        v.we     = (we != 0);
        v.be     = be[3:0];
        v.addr   = addr;
        v.wdata  = wdata;
        v.aid    = (aid != 0);
        v.rready = (rready != 0);
        v.eGnt   = (eGnt != 0);
        v.eValid = (eValid != 0);
        v.eData  = eData;
        v.eRid   = (eRid != 0);
        v.eErr   = (eErr != 0);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_i    = v.rst;
        req_i    = v.req;
        we_i     = v.we;
        be_i     = v.be;
        addr_i   = v.addr;
        wdata_i  = v.wdata;
        aid_i    = v.aid;
        rready_i = v.rready;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        vectorsApplied++;
        if (gnt_o !== v.eGnt || rvalid_o !== v.eValid || rdata_o !== v.eData ||
            rid_o !== v.eRid || err_o !== v.eErr) begin
            miscompares++;
            $display("[TB] FAIL %s: got gnt=%b rvalid=%b rdata=%h rid=%b err=%b, expected gnt=%b rvalid=%b rdata=%h rid=%b err=%b",
                     tag, gnt_o, rvalid_o, rdata_o, rid_o, err_o,
                     v.eGnt, v.eValid, v.eData, v.eRid, v.eErr);
        end
    endtask

    // Drive one cycle just after the rising edge and check mid-cycle on the falling edge
    task automatic runVec(input vec_t v, input string tag);
        @(posedge clk_i);
        #1;
        applyStimulus(v);
        @(negedge clk_i);
        checkOutput(v, tag);
    endtask

    // Main sequence: reset, vector table, then the multi-cycle corner cases
    initial begin
        rst_i    = 1'b1;
        req_i    = 1'b0;
        we_i     = 1'b0;
        be_i     = 4'h0;
        addr_i   = '0;
        wdata_i  = '0;
        aid_i    = '0;
        rready_i = 1'b1;
        repeat (2) @(posedge clk_i);

        //           rst req we be   addr      wdata         aid rdy  gnt vld data          rid err
        vecs.push_back(mk(1, 1, 0, 0,  32'h000, 32'h0,          0, 1,  0, 0, 32'h0,          0, 0));
        // write then read back one word
        vecs.push_back(mk(0, 1, 1, 15, 32'h008, 32'hA5A5_0F0F,  0, 1,  1, 0, 32'h0,          0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h008, 32'h0,          1, 1,  1, 1, 32'h0,          0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  32'h000, 32'h0,          0, 1,  0, 1, 32'hA5A5_0F0F,  1, 0));
        // partial byte-enable merge
        vecs.push_back(mk(0, 1, 1, 15, 32'h010, 32'h1122_3344,  0, 1,  1, 0, 32'h0,          0, 0));
        vecs.push_back(mk(0, 1, 1, 5,  32'h010, 32'hFFFF_FFFF,  1, 1,  1, 1, 32'h0,          0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h010, 32'h0,          0, 1,  1, 1, 32'h0,          1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  32'h000, 32'h0,          0, 1,  0, 1, 32'h11FF_33FF,  0, 0));
        // fill words 0, 1, 3 then stream reads of words 0..3
        vecs.push_back(mk(0, 1, 1, 15, 32'h000, 32'hDEAD_0000,  1, 1,  1, 0, 32'h0,          0, 0));
        vecs.push_back(mk(0, 1, 1, 15, 32'h004, 32'hDEAD_0001,  0, 1,  1, 1, 32'h0,          1, 0));
        vecs.push_back(mk(0, 1, 1, 15, 32'h00C, 32'hDEAD_0003,  1, 1,  1, 1, 32'h0,          0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h000, 32'h0,          0, 1,  1, 1, 32'h0,          1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h004, 32'h0,          1, 1,  1, 1, 32'hDEAD_0000,  0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h008, 32'h0,          0, 1,  1, 1, 32'hDEAD_0001,  1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h00C, 32'h0,          1, 1,  1, 1, 32'hA5A5_0F0F,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  32'h000, 32'h0,          0, 1,  0, 1, 32'hDEAD_0003,  1, 0));
        // out-of-range and misaligned accesses
        vecs.push_back(mk(0, 1, 1, 15, 32'h400, 32'hBAD0_BAD0,  0, 1,  1, 0, 32'h0,          0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h400, 32'h0,          1, 1,  1, 1, 32'h0,          0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  32'h002, 32'h0,          0, 1,  1, 1, 32'h0,          1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  32'h000, 32'h0,          1, 1,  1, 1, 32'h0,          0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  32'h000, 32'h0,          0, 1,  0, 1, 32'hDEAD_0000,  1, 0));
        // zero byte-enable write completes without touching memory
        vecs.push_back(mk(0, 1, 1, 0,  32'h004, 32'hFFFF_FFFF,  0, 1,  1, 0, 32'h0,          0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  32'h004, 32'h0,          1, 1,  1, 1, 32'h0,          0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  32'h000, 32'h0,          0, 1,  0, 1, 32'hDEAD_0001,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  32'h000, 32'h0,          0, 1,  0, 0, 32'h0,          0, 0));

        foreach (vecs[i]) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: rready low for 10 cycles while requests keep coming
        runVec(mk(0, 1, 0, 0, 32'h000, 32'h0, 0, 0,  1, 0, 32'h0,         0, 0), "bp_c0");
        runVec(mk(0, 1, 0, 0, 32'h004, 32'h0, 1, 0,  1, 1, 32'hDEAD_0000, 0, 0), "bp_c1");
        for (int c = 2; c < 10; c++) begin
            runVec(mk(0, 1, 0, 0, 32'h008, 32'h0, 0, 0,  0, 1, 32'hDEAD_0000, 0, 0),
                   $sformatf("bp_stall%0d", c));
        end
        runVec(mk(0, 1, 0, 0, 32'h008, 32'h0, 0, 1,  0, 1, 32'hDEAD_0000, 0, 0), "bp_c10");
        runVec(mk(0, 1, 0, 0, 32'h008, 32'h0, 0, 1,  1, 1, 32'hDEAD_0001, 1, 0), "bp_c11");
        runVec(mk(0, 0, 0, 0, 32'h000, 32'h0, 0, 1,  0, 1, 32'hA5A5_0F0F, 0, 0), "bp_c12");
        runVec(mk(0, 0, 0, 0, 32'h000, 32'h0, 0, 1,  0, 0, 32'h0,         0, 0), "bp_c13");

        // Reset pulse with two responses queued
        runVec(mk(0, 1, 0, 0, 32'h010, 32'h0, 1, 0,  1, 0, 32'h0,         0, 0), "rst_s0");
        runVec(mk(0, 1, 0, 0, 32'h00C, 32'h0, 0, 0,  1, 1, 32'h11FF_33FF, 1, 0), "rst_s1");
        runVec(mk(1, 1, 0, 0, 32'h000, 32'h0, 1, 0,  0, 1, 32'h11FF_33FF, 1, 0), "rst_s2");
        runVec(mk(0, 0, 0, 0, 32'h000, 32'h0, 0, 1,  0, 0, 32'h0,         0, 0), "rst_s3");
        runVec(mk(0, 0, 0, 0, 32'h000, 32'h0, 0, 1,  0, 0, 32'h0,         0, 0), "rst_s4");
        runVec(mk(0, 1, 0, 0, 32'h010, 32'h0, 0, 1,  1, 0, 32'h0,         0, 0), "rst_s5");
        runVec(mk(0, 0, 0, 0, 32'h000, 32'h0, 0, 1,  0, 1, 32'h11FF_33FF, 0, 0), "rst_s6");
        runVec(mk(0, 0, 0, 0, 32'h000, 32'h0, 0, 1,  0, 0, 32'h0,         0, 0), "rst_s7");

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
